rnd_dispenser: RTL and testbench

- Consumer end of the LFSR `next`/`rnd` interface.
- Drives `next` and captures each random tuple into a small prefetch FIFO.
- Hands one tuple per grant to up to NUM_CORE requesting event-processing cores through round-robin arbitration.
- Each tuple has three fields: delay, target LP and timestamp offset. This lets several cores share one LFSR without any core seeing the same tuple twice.

---
 rtl/rnd_dispenser.sv | 125 ++++++++++++
 tb/tb_rnd_dispenser.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rnd_dispenser.sv
// Prefetches LFSR tuples into a small FIFO and hands one tuple per grant to
// round-robin-arbitrated cores. Optional zero-delay skipping: RND_DISP_ZERO_SKIP_EN.
module rnd_dispenser #(
  parameter int NBITS    = 8,
  parameter int NUM_CORE = 4,
  parameter int DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         next,
  input  logic [3*NBITS-1:0]           rnd,
  input  logic                         flush,
  input  logic [NUM_CORE-1:0]          req,
  output logic [NUM_CORE-1:0]          gnt,
  output logic [3*NBITS-1:0]           rnd_out,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int TW = 3 * NBITS;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(NUM_CORE);

  // Handshakes: rnd is always valid and `next` is its ready (consume on next=1);
  // toward a core, req is a level request and gnt a single-cycle valid for rnd_out.

  logic [TW-1:0]       mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NUM_CORE-1:0] gnt_q, gnt_d;
  logic [TW-1:0]       rnd_out_q, rnd_out_d;

  logic [NUM_CORE-1:0] eligible;
  logic                win_found;
  logic [PW-1:0]       win_idx;
  logic [PW-1:0]       cand_idx;
  int                  cand;
  logic                pop;
  logic                push;

  // The just-granted core is masked so a core still dropping req is not regranted.
  assign eligible = req & ~gnt_q;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_CORE; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= NUM_CORE) cand = cand - NUM_CORE;
      cand_idx = PW'(cand);
      if (!win_found && eligible[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign pop  = win_found && (count_q != '0) && !flush;
  assign next = ((count_q < CW'(DEPTH)) || pop) && !flush && rst_n;

`ifdef RND_DISP_ZERO_SKIP_EN
  assign push = next && (rnd[NBITS-1:0] != '0);
`else
  assign push = next;
`endif

  always_comb begin
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = '0;
    rnd_out_d = rnd_out_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + AW'(1);
        gnt_d     = {{(NUM_CORE-1){1'b0}}, 1'b1} << win_idx;
        rnd_out_d = mem_q[rd_ptr_q];
        rr_ptr_d  = (win_idx == PW'(NUM_CORE - 1)) ? '0 : win_idx + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rr_ptr_q  <= '0;
      gnt_q     <= '0;
      rnd_out_q <= '0;
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      rnd_out_q <= rnd_out_d;
    end
  end

  // Storage needs no reset: push is held low during reset and flush.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rnd;
  end

  assign gnt     = gnt_q;
  assign rnd_out = rnd_out_q;
  assign count   = count_q;

endmodule

// File: tb/tb_rnd_dispenser.sv
// Bench for rnd_dispenser: stub LFSR source, vector table for the cycle-exact
// sequences, tuple-order scoreboard and a short random phase.
module tb_rnd_dispenser;

  localparam int NBITS    = 8;
  localparam int NUM_CORE = 4;
  localparam int DEPTH    = 4;
`ifdef RND_DISP_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        next;
  logic [23:0] rnd;
  logic        flush = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  gnt;
  logic [23:0] rnd_out;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rnd_dispenser #(.NBITS(NBITS), .NUM_CORE(NUM_CORE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .next(next), .rnd(rnd), .flush(flush),
    .req(req), .gnt(gnt), .rnd_out(rnd_out), .count(count)
  );

  // Stub LFSR: one 8-bit Fibonacci LFSR per field, advancing on next.
  logic [7:0] f0, f1, f2;
  logic       zero_force = 1'b0;

  function automatic logic [7:0] lfsr8(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      f0 <= 8'hE1; f1 <= 8'h34; f2 <= 8'hEF;
    end else if (next) begin
      f0 <= lfsr8(f0); f1 <= lfsr8(f1); f2 <= lfsr8(f2);
    end
  end

  assign rnd = {f2, f1, (zero_force ? 8'h00 : f0)};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Scoreboard: tuples consumed are queued in order; each grant pops one.
  logic [23:0] exp_q[$];
  logic        mon_en = 1'b0;
  logic [3:0]  prev_gnt = '0;

  always @(posedge clk) begin
    if (!rst_n || flush) exp_q.delete();
    else if (next && (!ZS || rnd[7:0] != 8'h00)) exp_q.push_back(rnd);
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (gnt != '0) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_underflow act=gnt_%b exp=no_grant", gnt);
        end else begin
          chk("sb_tuple", rnd_out, exp_q.pop_front());
        end
      end
      chk("sb_count", count, exp_q.size());
      chk("gnt_onehot0", $onehot0(gnt), 1);
      chk("gnt_back_to_back", gnt & prev_gnt, 0);
      prev_gnt = gnt;
    end
  end

  typedef struct {
    logic        rst_n;
    logic        flush;
    logic [3:0]  req;
    logic        exp_next;
    logic [2:0]  exp_cnt;
    logic [3:0]  exp_gnt;
    logic        chk_rnd;
    logic [23:0] exp_rnd;
  } vec_t;

  vec_t vecs[30];

  function automatic vec_t mk(input logic r, input logic f, input logic [3:0] q,
                              input logic n, input logic [2:0] c, input logic [3:0] g,
                              input logic cr, input logic [23:0] er);
    vec_t v;
    v.rst_n = r; v.flush = f; v.req = q; v.exp_next = n;
    v.exp_cnt = c; v.exp_gnt = g; v.chk_rnd = cr; v.exp_rnd = er;
    return v;
  endfunction

  logic [23:0] flush_rnd;

  initial begin
    // startup fill with no requests
    vecs[0]  = mk(1, 0, 4'b0000, 1, 0, 4'b0000, 1, 24'h0);
    vecs[1]  = mk(1, 0, 4'b0000, 1, 1, 4'b0000, 1, 24'h0);
    vecs[2]  = mk(1, 0, 4'b0000, 1, 2, 4'b0000, 1, 24'h0);
    vecs[3]  = mk(1, 0, 4'b0000, 1, 3, 4'b0000, 1, 24'h0);
    vecs[4]  = mk(1, 0, 4'b0000, 0, 4, 4'b0000, 1, 24'h0);
    vecs[5]  = mk(1, 0, 4'b0000, 0, 4, 4'b0000, 1, 24'h0);
    // round-robin with a full FIFO
    vecs[6]  = mk(1, 0, 4'b1111, 1, 4, 4'b0000, 0, 24'h0);
    vecs[7]  = mk(1, 0, 4'b1111, 1, 4, 4'b0001, 1, 24'hEF34E1);
    vecs[8]  = mk(1, 0, 4'b1111, 1, 4, 4'b0010, 0, 24'h0);
    vecs[9]  = mk(1, 0, 4'b1111, 1, 4, 4'b0100, 0, 24'h0);
    vecs[10] = mk(1, 0, 4'b1111, 1, 4, 4'b1000, 0, 24'h0);
    vecs[11] = mk(1, 0, 4'b0000, 0, 4, 4'b0001, 0, 24'h0);
    vecs[12] = mk(1, 0, 4'b0000, 0, 4, 4'b0000, 0, 24'h0);
    // flush when full, refill to 3, flush with a pending request
    vecs[13] = mk(1, 1, 4'b0000, 0, 4, 4'b0000, 0, 24'h0);
    vecs[14] = mk(1, 0, 4'b0000, 1, 0, 4'b0000, 0, 24'h0);
    vecs[15] = mk(1, 0, 4'b0000, 1, 1, 4'b0000, 0, 24'h0);
    vecs[16] = mk(1, 0, 4'b0000, 1, 2, 4'b0000, 0, 24'h0);
    vecs[17] = mk(1, 1, 4'b0010, 0, 3, 4'b0000, 0, 24'h0);
    vecs[18] = mk(1, 0, 4'b0010, 1, 0, 4'b0000, 0, 24'h0);
    vecs[19] = mk(1, 0, 4'b0010, 1, 1, 4'b0000, 0, 24'h0);
    vecs[20] = mk(1, 0, 4'b0010, 1, 1, 4'b0010, 0, 24'h0);
    vecs[21] = mk(1, 0, 4'b0000, 1, 2, 4'b0000, 0, 24'h0);
    // reset during active grants, then first-tuple request from cycle 1
    vecs[22] = mk(1, 0, 4'b1111, 1, 3, 4'b0000, 0, 24'h0);
    vecs[23] = mk(0, 0, 4'b1111, 0, 3, 4'b0100, 0, 24'h0);
    vecs[24] = mk(1, 0, 4'b0000, 1, 0, 4'b0000, 1, 24'h0);
    vecs[25] = mk(1, 0, 4'b0100, 1, 1, 4'b0000, 1, 24'h0);
    vecs[26] = mk(1, 0, 4'b0100, 1, 1, 4'b0100, 1, 24'hEF34E1);
    vecs[27] = mk(1, 0, 4'b0000, 1, 2, 4'b0000, 0, 24'h0);
    vecs[28] = mk(1, 0, 4'b0000, 1, 3, 4'b0000, 0, 24'h0);
    vecs[29] = mk(1, 0, 4'b0000, 0, 4, 4'b0000, 0, 24'h0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_next", next, 0);
    chk("rst_count", count, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_rnd_out", rnd_out, 0);
    mon_en = 1'b1;

    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      rst_n = vecs[i].rst_n;
      flush = vecs[i].flush;
      req   = vecs[i].req;
      @(negedge clk);
      if (i == 17) flush_rnd = rnd;
      chk($sformatf("row%0d_next", i), next, vecs[i].exp_next);
      chk($sformatf("row%0d_count", i), count, vecs[i].exp_cnt);
      chk($sformatf("row%0d_gnt", i), gnt, vecs[i].exp_gnt);
      if (vecs[i].chk_rnd) chk($sformatf("row%0d_rnd_out", i), rnd_out, vecs[i].exp_rnd);
      if (i == 20) chk("post_flush_tuple", rnd_out, flush_rnd);
    end

    // zero-delay tuples: flush, then force delay field to 0 for two cycles
    @(posedge clk); #1; flush = 1'b1; req = '0;
    @(negedge clk); chk("zs_flush_next", next, 0);
    @(posedge clk); #1; flush = 1'b0; zero_force = 1'b1;
    @(negedge clk); chk("zs_a_count", count, 0); chk("zs_a_next", next, 1);
    @(posedge clk); #1;
    @(negedge clk); chk("zs_b_count", count, ZS ? 0 : 1); chk("zs_b_next", next, 1);
    @(posedge clk); #1; zero_force = 1'b0; req = 4'b0001;
    @(negedge clk); chk("zs_c_count", count, ZS ? 0 : 2);
    @(posedge clk); #1;
    @(negedge clk);
`ifdef RND_DISP_ZERO_SKIP_EN
    chk("zs_d_gnt", gnt, 4'b0000);
    chk("zs_d_count", count, 1);
`else
    chk("zs_d_gnt", gnt, 4'b0001);
    chk("zs_d_delay", rnd_out[7:0], 8'h00);
`endif
    @(posedge clk); #1; req = '0;
    @(negedge clk);
`ifdef RND_DISP_ZERO_SKIP_EN
    chk("zs_e_gnt", gnt, 4'b0001);
    chk("zs_e_delay_nz", rnd_out[7:0] != 8'h00, 1);
`else
    chk("zs_e_gnt", gnt, 4'b0000);
`endif

    // random requests and occasional flushes, checked by the scoreboard
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      req   = 4'($urandom_range(0, 15));
      flush = ($urandom_range(0, 15) == 0);
    end
    @(posedge clk); #1; req = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
